image_frame_loader: RTL

//  Writer side of the CNN image buffer: accepts a raster pixel stream (valid/ready) and writes one
//  IMG_W x IMG_H grayscale frame into the 16-bit image memory the cnn controller reads.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/raster_counter.sv | 58 +++++
 rtl/image_frame_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image geometry and loader state encoding for the cnn image buffer
package cnn_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 14;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        LOAD     = 2'd1,
        FULL     = 2'd2
    } loader_state_e;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - col/row raster position with clear/start/increment and linear address
module raster_counter #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic              inc,
    output logic              last_col,
    output logic              last_pix,
    output logic [ADDR_W-1:0] addr
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_pix = last_col && (row_q == ROW_W'(IMG_H - 1));
    assign addr     = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);

    // Next position: clear wins, start places the counter just after pixel (0,0), inc walks the raster.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (start) begin
            col_d = COL_W'(1);
            row_d = '0;
        end else if (inc) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/image_frame_loader.sv
// rtl/image_frame_loader.sv - pixel stream to image memory writer with framing checks and frame hold
module image_frame_loader #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int PIX_W  = cnn_pkg::PIX_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              frame_ready,
    input  logic              frame_release,
    output logic              err_sof,
    output logic              err_line,
    output logic [7:0]        frame_count
);

    import cnn_pkg::*;

    loader_state_e     state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              err_sof_q, err_sof_d;
    logic              err_line_q, err_line_d;
    logic              frame_ready_q, frame_ready_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic              cnt_clear, cnt_start, cnt_inc;
    logic              cnt_last_col, cnt_last_pix;
    logic [ADDR_W-1:0] cnt_addr;
    logic              accept;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .start   (cnt_start),
        .inc     (cnt_inc),
        .last_col(cnt_last_col),
        .last_pix(cnt_last_pix),
        .addr    (cnt_addr)
    );

    assign accept      = s_valid && s_ready_q;
    assign s_ready     = s_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_sof     = err_sof_q;
    assign err_line    = err_line_q;
    assign frame_ready = frame_ready_q;
    assign frame_count = frame_count_q;

    // Loader FSM: framing checks on each accepted beat decide write, error pulse and raster update.
    always_comb begin
        state_d       = state_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = {{(16 - PIX_W){1'b0}}, s_data};
        err_sof_d     = 1'b0;
        err_line_d    = 1'b0;
        frame_count_d = frame_count_q;
        cnt_clear     = 1'b0;
        cnt_start     = 1'b0;
        cnt_inc       = 1'b0;
        if (!mem_we_d) begin
            mem_wdata_d = mem_wdata_q;
        end

        case (state_q)
            WAIT_SOF: begin
                if (accept) begin
                    if (s_sof) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = '0;
                        mem_wdata_d = {{(16 - PIX_W){1'b0}}, s_data};
                        cnt_start   = 1'b1;
                        state_d     = LOAD;
                    end else begin
                        err_sof_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (s_sof) begin
                        // A fresh SOF mid-frame restarts the frame with this beat as pixel (0,0).
                        err_sof_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = '0;
                        mem_wdata_d = {{(16 - PIX_W){1'b0}}, s_data};
                        cnt_start   = 1'b1;
                    end else if (s_eol != cnt_last_col) begin
                        err_line_d = 1'b1;
                        cnt_clear  = 1'b1;
                        state_d    = WAIT_SOF;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cnt_addr;
                        mem_wdata_d = {{(16 - PIX_W){1'b0}}, s_data};
                        if (cnt_last_pix) begin
                            cnt_clear     = 1'b1;
                            frame_count_d = frame_count_q + 8'd1;
                            state_d       = FULL;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            FULL: begin
                if (frame_release) begin
                    state_d = WAIT_SOF;
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase
    end

    // Status outputs lag the state by one cycle so frame_ready follows the final write strobe.
    always_comb begin
        s_ready_d     = (state_d != FULL);
        frame_ready_d = (state_q == FULL) && !frame_release;
    end

    // State, registered write port and status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_SOF;
            s_ready_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            err_sof_q     <= 1'b0;
            err_line_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= s_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            err_sof_q     <= err_sof_d;
            err_line_q    <= err_line_d;
            frame_ready_q <= frame_ready_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
